// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: state encodings and
// widths common to the arbiter and the 32 x 8 FIFO it feeds.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int FIFO_DW    = 8;
    localparam int FIFO_DEPTH = 32;
    localparam int STAT_W     = 16;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: returns the first set bit of req at or after
// start, wrapping modulo N (N need not be a power of two).
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N);

    logic [IDX_W:0] sum [N];
    logic [IDX_W:0] pos [N];
    logic [N-1:0]   rot;

    // One extra bit of headroom keeps start+offset from overflowing before the wrap.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            assign sum[gi] = {1'b0, start} + (IDX_W + 1)'(gi);
            assign pos[gi] = (sum[gi] >= N_W) ? (sum[gi] - N_W) : sum[gi];
            assign rot[gi] = req[pos[gi][IDX_W-1:0]];
        end
    endgenerate

    always_comb begin
        logic found;
        found = 1'b0;
        idx   = '0;
        any   = |req;
        for (int k = 0; k < N; k++) begin
            if (rot[k] && !found) begin
                idx   = pos[k][IDX_W-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-capped arbiter driving the FIFO write port.
// Optional per-requester accepted-beat counters: define ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int DW        = FIFO_DW,
    parameter int MAX_BURST = 4,
    parameter int IDX_W     = $clog2(N)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [N-1:0]      req,
    input  logic [N*DW-1:0]   req_data,
    input  logic              fifo_full,
    output logic [N-1:0]      gnt,
    output logic              fifo_wr_en,
    output logic [DW-1:0]     fifo_data,
    output logic [IDX_W-1:0]  owner,
    output logic              busy
`ifdef ARB_STATS_EN
    ,
    output logic [N*STAT_W-1:0] stat_beats
`endif
);

    localparam int BC_W = $clog2(MAX_BURST + 1);
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(MAX_BURST - 1);

    arb_state_t      state_reg, state_next;
    logic [IDX_W-1:0] owner_reg, owner_next;
    logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [BC_W-1:0]  beat_cnt_reg, beat_cnt_next;

    logic [IDX_W-1:0] owner_inc;
    logic [IDX_W-1:0] pick_start;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             accept;
    logic             release_now;
    logic [DW-1:0]    slice [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slice
            assign slice[gi] = req_data[gi*DW +: DW];
        end
    endgenerate

    assign owner_inc  = (owner_reg == IDX_W'(N - 1)) ? '0 : owner_reg + 1'b1;
    // On release the search starts after the old owner, so it is considered last.
    assign pick_start = (state_reg == BUSY) ? owner_inc : rr_ptr_reg;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .start (pick_start),
        .any   (pick_any),
        .idx   (pick_idx)
    );

    assign accept      = (state_reg == BUSY) && req[owner_reg] && !fifo_full;
    assign release_now = (state_reg == BUSY) &&
                         ((accept && (beat_cnt_reg == LAST_BEAT)) || !req[owner_reg]);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg    <= IDLE;
            owner_reg    <= '0;
            rr_ptr_reg   <= '0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            rr_ptr_reg   <= rr_ptr_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        rr_ptr_next   = rr_ptr_reg;
        beat_cnt_next = beat_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    state_next    = BUSY;
                    owner_next    = pick_idx;
                    beat_cnt_next = '0;
                end
            end
            BUSY: begin
                if (release_now) begin
                    rr_ptr_next   = owner_inc;
                    beat_cnt_next = '0;
                    if (pick_any) begin
                        owner_next = pick_idx;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (accept) begin
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_reg == BUSY);
        owner      = owner_reg;
        fifo_wr_en = accept;
        gnt        = accept ? (N'(1) << owner_reg) : '0;
        fifo_data  = busy ? slice[owner_reg] : '0;
    end

`ifdef ARB_STATS_EN
    logic [STAT_W-1:0] stat_reg [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_stat
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    stat_reg[gi] <= '0;
                end else if (gnt[gi] && (stat_reg[gi] != {STAT_W{1'b1}})) begin
                    stat_reg[gi] <= stat_reg[gi] + 1'b1;
                end
            end
            assign stat_beats[gi*STAT_W +: STAT_W] = stat_reg[gi];
        end
    endgenerate
`endif

endmodule
